// File: rtl/gray_fifo_pkg.sv
// rtl/gray_fifo_pkg.sv - shared Gray/binary helpers and widths for the Gray-pointer FIFO controller
package gray_fifo_pkg;

  localparam int DEPTH_W_DEF = 4;
  localparam int PTR_W_DEF   = DEPTH_W_DEF + 1;
  // Helpers work on a fixed wide vector; callers cast to their pointer width.
  localparam int MAX_W       = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr.sv
// rtl/gray_ptr.sv - Gray-coded pointer register with binary view and next-state outputs
module gray_ptr
  import gray_fifo_pkg::*;
#(
  parameter int W = PTR_W_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] gray_q,
  output logic [W-1:0] bin_q,
  output logic [W-1:0] gray_next,
  output logic [W-1:0] bin_next
);

  always_comb begin
    bin_q    = W'(gray2bin(MAX_W'(gray_q)));
    bin_next = bin_q;
    if (clr) begin
      bin_next = '0;
    end else if (inc) begin
      bin_next = bin_q + 1'b1;
    end
    gray_next = W'(bin2gray(MAX_W'(bin_next)));
  end

  // Only Gray state is stored so the exported value never shows multi-bit transitions.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_next;
    end
  end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// rtl/gray_fifo_ctrl.sv - single-clock FIFO controller: Gray pointers, RAM strobes, full/empty/level flags
module gray_fifo_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clr,
  input  logic               w_req,
  input  logic               r_req,
  output logic               w_en,
  output logic [DEPTH_W-1:0] w_addr,
  output logic               r_en,
  output logic [DEPTH_W-1:0] r_addr,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W:0]   usedw,
  output logic [DEPTH_W:0]   wptr_gray,
  output logic [DEPTH_W:0]   rptr_gray,
  output logic               fail
);

  localparam int PTR_W = DEPTH_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  // Gray code of "pointers differ by depth": top two bits inverted, rest equal.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (PTR_W - 2);

  ptr_t wgray_q, wbin_q, wgray_next, wbin_next;
  ptr_t rgray_q, rbin_q, rgray_next, rbin_next;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic fail_q, fail_d;
  ptr_t usedw_q, usedw_d;

  always_comb begin
    w_en = w_req & ~full_q & ~clr;
    r_en = r_req & ~empty_q & ~clr;
  end

  gray_ptr #(.W(PTR_W)) u_wptr (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (clr),
    .inc       (w_en),
    .gray_q    (wgray_q),
    .bin_q     (wbin_q),
    .gray_next (wgray_next),
    .bin_next  (wbin_next)
  );

  gray_ptr #(.W(PTR_W)) u_rptr (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (clr),
    .inc       (r_en),
    .gray_q    (rgray_q),
    .bin_q     (rbin_q),
    .gray_next (rgray_next),
    .bin_next  (rbin_next)
  );

  always_comb begin
    empty_d = (wgray_next == rgray_next);
    full_d  = (wgray_next == (rgray_next ^ FULL_MASK));
    usedw_d = wbin_next - rbin_next;
    fail_d  = ~clr & ((w_req & full_q) | (r_req & empty_q));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      usedw_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      empty_q <= empty_d;
      usedw_q <= usedw_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    w_addr    = wbin_q[DEPTH_W-1:0];
    r_addr    = rbin_q[DEPTH_W-1:0];
    full      = full_q;
    empty     = empty_q;
    usedw     = usedw_q;
    wptr_gray = wgray_q;
    rptr_gray = rgray_q;
    fail      = fail_q;
  end

endmodule
